// File: rtl/sprite_pkg.sv
// Shared screen geometry, colour width and animator state encoding.
package sprite_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        HOLD  = 3'd2,
        ERASE = 3'd3,
        DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/sprite_animator_if.sv
// Host/ROM/VGA signal bundle for the sprite animator; master is the host side.
interface sprite_animator_if
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 16
) ();
    logic                start;
    logic                stop;
    logic                loop;
    logic [8:0]          x_pos;
    logic [7:0]          y_pos;
    logic [ADDR_W-1:0]   rom_addr;
    logic [COLOUR_W-1:0] rom_data;
    logic [8:0]          vga_x;
    logic [7:0]          vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                frame_done;
    logic                done;

    modport master (
        output start, stop, loop, x_pos, y_pos, rom_data,
        input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done, done
    );

    modport slave (
        input  start, stop, loop, x_pos, y_pos, rom_data,
        output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, frame_done, done
    );
endinterface

// File: rtl/raster_scanner.sv
// Column/row raster counter over an SPR_W x SPR_H box; wraps to (0,0) after the last pixel.
module raster_scanner #(
    parameter int SPR_W = 80,
    parameter int SPR_H = 120,
    localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          end_col;

    always_comb begin
        end_col = (col_q == CW'(SPR_W - 1));
        last    = end_col && (row_q == RW'(SPR_H - 1));
        col_d   = col_q;
        row_d   = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            col_d = end_col ? '0 : col_q + 1'b1;
            if (end_col)
                row_d = last ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;
endmodule

// File: rtl/sprite_animator.sv
// Animated sprite blitter: draws a ROM frame, holds it, erases its box, then
// advances/loops/stops. Pixel coordinates go through one stage to meet rom_data.
module sprite_animator
    import sprite_pkg::*;
#(
    parameter int                  SPR_W       = 80,
    parameter int                  SPR_H       = 120,
    parameter int                  FRAMES      = 4,
    parameter int                  HOLD_CYCLES = 200000000,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b000,
    parameter bit                  TRANSP_EN   = 1'b0,
    parameter logic [COLOUR_W-1:0] TRANSP_KEY  = 3'b111,
    parameter int                  ADDR_W      = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                stop,
    input  logic [8:0]          x_pos,
    input  logic [7:0]          y_pos,
    input  logic                loop,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [8:0]          vga_x,
    output logic [7:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                frame_done,
    output logic                done
);
    localparam int PIX = SPR_W * SPR_H;
    localparam int CW  = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW  = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int FW  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [8:0]    x_lat_q, x_lat_d;
    logic [7:0]    y_lat_q, y_lat_d;
    logic          loop_q, loop_d;
    logic          stop_q, stop_d;
    logic          fd_q, fd_d;

    logic          scan_clear, scan_step, scan_last;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic          issuing, off_scr;
    logic [9:0]    sum_x;
    logic [8:0]    sum_y;
    logic          vld_q, erase_q, off_q;
    logic [8:0]    px_q;
    logic [7:0]    py_q;
    logic          transp;

    raster_scanner #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_scan (
        .clk    (clk),
        .resetn (resetn),
        .clear  (scan_clear),
        .step   (scan_step),
        .col    (col),
        .row    (row),
        .last   (scan_last)
    );

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        timer_d    = timer_q;
        x_lat_d    = x_lat_q;
        y_lat_d    = y_lat_q;
        loop_d     = loop_q;
        stop_d     = stop_q | (stop && (state_q != IDLE));
        fd_d       = 1'b0;
        scan_clear = 1'b0;
        scan_step  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                x_lat_d    = x_pos;
                y_lat_d    = y_pos;
                loop_d     = loop;
                frame_d    = '0;
                stop_d     = 1'b0;
                scan_clear = 1'b1;
                state_d    = DRAW;
            end
            DRAW: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (timer_q == TW'(HOLD_CYCLES - 1))
                    state_d = ERASE;
                else
                    timer_d = timer_q + 1'b1;
            end
            ERASE: begin
                scan_step = 1'b1;
                if (scan_last) begin
                    fd_d = 1'b1;
                    // stop is checked combinationally too so a same-cycle request still lands
                    if (stop_q || stop) begin
                        state_d = DONE;
                    end else if (frame_q != FW'(FRAMES - 1)) begin
                        frame_d = frame_q + 1'b1;
                        state_d = DRAW;
                    end else if (loop_q) begin
                        frame_d = '0;
                        state_d = DRAW;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                frame_d = '0;
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            frame_q <= '0;
            timer_q <= '0;
            x_lat_q <= '0;
            y_lat_q <= '0;
            loop_q  <= 1'b0;
            stop_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            timer_q <= timer_d;
            x_lat_q <= x_lat_d;
            y_lat_q <= y_lat_d;
            loop_q  <= loop_d;
            stop_q  <= stop_d;
            fd_q    <= fd_d;
        end
    end

    // Carry bits flag coordinates that wrapped past 511/255 as off-screen.
    always_comb begin
        issuing = (state_q == DRAW) || (state_q == ERASE);
        sum_x   = {1'b0, x_lat_q} + 10'(col);
        sum_y   = {1'b0, y_lat_q} + 9'(row);
        off_scr = sum_x[9] || sum_y[8] ||
                  (sum_x[8:0] >= 9'(SCREEN_W)) || (sum_y[7:0] >= 8'(SCREEN_H));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q   <= 1'b0;
            erase_q <= 1'b0;
            off_q   <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            vld_q   <= issuing;
            erase_q <= (state_q == ERASE);
            off_q   <= off_scr;
            px_q    <= issuing ? sum_x[8:0] : 9'd0;
            py_q    <= issuing ? sum_y[7:0] : 8'd0;
        end
    end

    always_comb begin
        rom_addr = '0;
        if (state_q == DRAW)
            rom_addr = ADDR_W'(frame_q) * ADDR_W'(PIX) + ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end

    assign transp     = TRANSP_EN && !erase_q && (rom_data == TRANSP_KEY);
    assign vga_x      = px_q;
    assign vga_y      = py_q;
    assign vga_colour = vld_q ? (erase_q ? BG_COLOUR : rom_data) : '0;
    assign vga_plot   = vld_q && !off_q && !transp;
    assign busy       = (state_q != IDLE);
    assign frame_done = fd_q;
    assign done       = (state_q == DONE);
endmodule

// File: tb/tb_sprite_animator.sv
// Randomised bench for sprite_animator: a timeline model (cycle offset since start)
// predicts every output each cycle; directed runs pin key literal values.
module tb_sprite_animator;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int FR   = 2;
    localparam int HC   = 5;
    localparam int PIX  = W * H;
    localparam int P    = 2 * PIX + HC;
    localparam int INF  = 1000000;
    localparam logic [2:0] BG  = 3'b000;
    localparam logic [2:0] KEY = 3'b111;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #10 clk = ~clk;

    sprite_animator_if #(.ADDR_W(16)) bus ();

    sprite_animator #(
        .SPR_W(W), .SPR_H(H), .FRAMES(FR), .HOLD_CYCLES(HC),
        .BG_COLOUR(BG), .TRANSP_EN(1'b1), .TRANSP_KEY(KEY), .ADDR_W(16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (bus.start),
        .stop       (bus.stop),
        .x_pos      (bus.x_pos),
        .y_pos      (bus.y_pos),
        .loop       (bus.loop),
        .rom_addr   (bus.rom_addr),
        .rom_data   (bus.rom_data),
        .vga_x      (bus.vga_x),
        .vga_y      (bus.vga_y),
        .vga_colour (bus.vga_colour),
        .vga_plot   (bus.vga_plot),
        .busy       (bus.busy),
        .frame_done (bus.frame_done),
        .done       (bus.done)
    );

    logic [2:0] rom [0:FR*PIX-1];
    always @(posedge clk)
        bus.rom_data <= (bus.rom_addr < 16'(FR*PIX)) ? rom[bus.rom_addr[4:0]] : 3'd0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // ---- timeline model: t counts cycles since the start was taken ----
    bit         m_act  = 1'b0;
    int         m_t    = 0;
    int         m_kend = 0;
    logic [8:0] m_x    = '0;
    logic [7:0] m_y    = '0;

    function automatic int new_kend(int kend, int t);
        if (t < (kend + 1) * P && t / P < kend) return t / P;
        return kend;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_act <= 1'b0;
            m_t   <= 0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act  <= 1'b1;
                m_t    <= 0;
                m_x    <= bus.x_pos;
                m_y    <= bus.y_pos;
                m_kend <= bus.loop ? INF : FR - 1;
            end
        end else begin
            if (bus.stop) m_kend <= new_kend(m_kend, m_t);
            m_t <= m_t + 1;
            if (m_t == (m_kend + 1) * P) m_act <= 1'b0;
        end
    end

    function automatic logic [39:0] expect_out();
        logic [15:0] a  = '0;
        logic [8:0]  vx = '0;
        logic [7:0]  vy = '0;
        logic [2:0]  c  = '0;
        logic        pl = 1'b0, bz = 1'b0, fd = 1'b0, dn = 1'b0;
        int k, ph, f, idx, xs, ys, endt;
        bit have, er;
        have = 1'b0; er = 1'b0; idx = 0;
        if (m_act) begin
            endt = (m_kend + 1) * P;
            k  = m_t / P;
            ph = m_t % P;
            f  = k % FR;
            bz = 1'b1;
            dn = (m_t == endt);
            fd = (m_t > 0 && ph == 0);
            if (ph < PIX && !dn) a = 16'(f * PIX + ph);
            if (ph >= 1 && ph <= PIX) begin have = 1'b1; idx = ph - 1; end
            else if (ph > PIX + HC) begin have = 1'b1; er = 1'b1; idx = ph - PIX - HC - 1; end
            else if (ph == 0 && m_t > 0) begin have = 1'b1; er = 1'b1; idx = PIX - 1; end
            if (have) begin
                xs = int'(m_x) + idx % W;
                ys = int'(m_y) + idx / W;
                vx = 9'(xs);
                vy = 8'(ys);
                c  = er ? BG : rom[f * PIX + idx];
                pl = (xs < 320) && (ys < 240) && !(!er && c == KEY);
            end
        end
        return {a, vx, vy, c, pl, bz, fd, dn};
    endfunction

    function automatic logic [39:0] dut_out();
        return {bus.rom_addr, bus.vga_x, bus.vga_y, bus.vga_colour,
                bus.vga_plot, bus.busy, bus.frame_done, bus.done};
    endfunction

    bit mon_en = 1'b0;
    int n_plot = 0, n_off = 0, n_done = 0, n_fd = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("cycle_outputs", 64'(dut_out()), 64'(expect_out()));
            if (bus.vga_plot) begin
                n_plot++;
                if (bus.vga_x >= 9'd320) n_off++;
            end
            if (bus.done) n_done++;
            if (bus.frame_done) n_fd++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [8:0] x, input logic [7:0] y, input logic lp);
        bus.x_pos = x;
        bus.y_pos = y;
        bus.loop  = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        for (int i = 0; i < max_cyc && bus.busy; i++) tick();
        check(nm, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int p0, o0, d0, f0;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, wanted finish before 2ms");
        $fatal(1);
    end

    initial begin
        int p0, o0, d0, f0;
        for (int i = 0; i < FR * PIX; i++) rom[i] = 3'($urandom_range(0, 6));
        rom[5] = 3'b111;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        bus.x_pos = '0;   bus.y_pos = '0;
        mon_en = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 64'(dut_out()), 64'd0);
        resetn = 1'b1;
        tick();

        // basic two-frame run at (10,20)
        p0 = n_plot; d0 = n_done; f0 = n_fd;
        do_start(9'd10, 8'd20, 1'b0);
        check("first_addr", 64'(bus.rom_addr), 64'd0);
        tick();
        check("first_pixel", 64'({bus.vga_x, bus.vga_y, bus.vga_plot}), 64'({9'd10, 8'd20, 1'b1}));
        check("second_addr", 64'(bus.rom_addr), 64'd1);
        wait_idle("basic_idle", 200);
        check("basic_plots", 64'(n_plot - p0), 64'd47);
        check("basic_frame_done", 64'(n_fd - f0), 64'd2);
        check("basic_done", 64'(n_done - d0), 64'd1);

        // looping run, stop during HOLD of the third frame
        p0 = n_plot; d0 = n_done; f0 = n_fd;
        do_start(9'd0, 8'd0, 1'b1);
        repeat (2 * P) tick();
        check("loop_addr_wrap", 64'({bus.rom_addr, bus.frame_done}), 64'({16'd0, 1'b1}));
        check("loop_no_done", 64'(n_done - d0), 64'd0);
        repeat (PIX + 2) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wait_idle("loop_idle", 200);
        check("loop_plots", 64'(n_plot - p0), 64'd70);
        check("loop_frame_done", 64'(n_fd - f0), 64'd3);
        check("loop_done", 64'(n_done - d0), 64'd1);

        // right-edge clipping
        p0 = n_plot; o0 = n_off;
        do_start(9'd318, 8'd230, 1'b0);
        wait_idle("clip_idle", 200);
        check("clip_plots", 64'(n_plot - p0), 64'd23);
        check("clip_offscreen", 64'(n_off - o0), 64'd0);

        // reset mid-DRAW, then restart from frame 0
        do_start(9'd100, 8'd100, 1'b0);
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", 64'(dut_out()), 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        do_start(9'd30, 8'd40, 1'b0);
        check("restart_addr", 64'({bus.rom_addr, bus.busy}), 64'({16'd0, 1'b1}));
        tick();
        check("restart_x", 64'(bus.vga_x), 64'd30);
        wait_idle("restart_idle", 200);

        // start during HOLD is ignored; start+stop in IDLE takes start
        d0 = n_done; f0 = n_fd;
        bus.stop = 1'b1;
        do_start(9'd50, 8'd60, 1'b0);
        bus.stop = 1'b0;
        repeat (PIX + 2) tick();
        do_start(9'd200, 8'd10, 1'b1);
        wait_idle("hold_start_idle", 200);
        check("hold_start_frames", 64'(n_fd - f0), 64'd2);
        check("hold_start_done", 64'(n_done - d0), 64'd1);

        // randomised runs
        for (int r = 0; r < 10; r++) begin
            bus.stop = ($urandom_range(0, 3) == 0);
            do_start(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            for (int c = 0; c < 400 && bus.busy; c++) begin
                bus.stop  = (c >= 150) || ($urandom_range(0, 59) == 0);
                bus.start = ($urandom_range(0, 19) == 0);
                bus.x_pos = 9'($urandom_range(0, 511));
                tick();
            end
            bus.stop = 1'b0; bus.start = 1'b0;
            check("rand_idle", 64'(bus.busy), 64'd0);
            repeat ($urandom_range(1, 4)) tick();
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
